pdecoder_acc: RTL and testbench
===============================

# pdecoder_acc

Sequential index-to-vector decoder: the inverse of the 8:3 priority encoder. It accepts a stream of encoded indices over a valid/ready handshake and one-hot decodes each into an accumulating request vector. On the frame's last beat it presents the rebuilt vector, with a beat count and a duplicate flag, over a second valid/ready handshake. Typical use is rebuilding the request vector on the far side of a link that carries encoder indices.

## Interface
Parameters:
- `N`, 3: index width; the vector width is `W = 2**N` (8 by default).

Ports:
- `clk`, input, 1: the only clock; all logic is on its rising edge.
- `rst`, input, 1: reset, synchronous and active-high.
- `in_valid`, input, 1: `idx` and `last` are valid.
- `in_ready`, output, 1: the block can accept an index.
- `idx`, input, N: encoded index to decode.
- `last`, input, 1: this beat closes the frame.
- `out_valid`, output, 1: the frame result is valid.
- `out_ready`, input, 1: the downstream block accepts the result.
- `out`, output, W: accumulated one-hot OR of the frame's indices.
- `count`, output, N+1: number of beats accepted in the frame, saturating at all-ones.
- `dup`, output, 1: at least one index in the frame repeated a bit that was already set.

## Operation
- There are two states, ACC and OUT, and both are registered.
- Internal registers: `vec` (W bits), `cnt` (N+1 bits), `dupr` (1 bit).
- ACC:
  - `in_ready=1`, `out_valid=0`.
  - A beat is accepted when `in_valid & in_ready`.
  - Per accepted beat: `vec <= vec | (1<<idx)`.
  - Per accepted beat: `cnt <= sat(cnt+1)`.
  - Per accepted beat: `dupr <= dupr | vec[idx]`.
  - If `last=1` on the accepted beat, the next state is OUT. `out`, `count` and `dup` then load the updated values, including the last beat.
- OUT:
  - `in_ready=0`, so `in_valid` is ignored and no beat is accepted.
  - `out_valid=1`. `out`, `count` and `dup` hold stable until the handshake completes.
  - When `out_valid & out_ready`: `vec`, `cnt` and `dupr` clear, and the next state is ACC.
- Single-beat frame (`last=1` on the first beat): `out` is one-hot and `count=1`.
- Counter saturation: `cnt` stops at 2^(N+1)-1 (15 by default). It never wraps. `vec` is unaffected.
- `dup` is sticky within a frame and clears only at output handshake or reset.
- Outputs `out`, `count`, `dup` read as 0 while in ACC. They are registered outputs, not a view of `vec`.
- Reset:
  - State is ACC.
  - `vec=0`, `cnt=0`, `dupr=0`.
  - `out_valid=0`, `out=0`, `count=0`, `dup=0`.
  - `in_ready=1` from the first cycle after reset deasserts.
- Reset asserted mid-frame or in OUT discards the partial or pending frame with no output. Reset has priority over every handshake in the same cycle.
- The index range is always legal; every `idx` value maps to a bit.

## Timing
- `in_ready` and `out_valid` are state decodes, with no combinational path from `in_valid` or `out_ready`.
- Latency: `out_valid` rises on the cycle after the edge that accepted the `last` beat.
- OUT lasts at least one cycle. When `out_ready` is already high, it lasts exactly one cycle.
- In the cycle after the output handshake, `in_ready=1` again.
- Throughput: a frame of k beats needs a minimum of k+1 cycles.
- Backpressure:
  - `out_ready` low holds OUT indefinitely.
  - Upstream stalls because `in_ready=0`.
  - No beat is lost or duplicated.
- Simultaneous events:
  - In OUT, `in_valid=1` together with the output handshake is not accepted in that cycle.
  - In ACC, `out_ready` has no effect.

## Test plan
- Reset, then check:
  - `in_ready=1`, `out_valid=0`.
  - `out=0`, `count=0`, `dup=0`.
- Frame idx 5, 4, 1 (last on 1), with `out_ready=1`:
  - `out_valid` is high for exactly 1 cycle, the cycle after the beat with idx 1.
  - `out=8'b00110010`, `count=3`, `dup=0`.
  - `in_ready` returns high in the cycle after the handshake.
- Frame idx 1, 1 (last), then idx 0 (last):
  - First result: `out=8'b00000010`, `count=2`, `dup=1`.
  - Second result: `out=8'b00000001`, `count=1`, `dup=0`. This proves the clear.
- Frame idx 2, 0 (last) with `out_ready=0` for 5 cycles, with upstream holding `in_valid=1`:
  - `out=8'b00000101` holds stable.
  - `in_ready=0` throughout, and no extra beat is counted.
  - Then `out_ready=1` completes the handshake.
- 17 beats of idx 7, last on beat 17:
  - `out=8'b10000000`, `count=15` (saturated), `dup=1`.
- Two beats of idx 3 and 6, then `rst` for 1 cycle, then idx 0 (last):
  - No output appears for the aborted frame.
  - Result: `out=8'b00000001`, `count=1`, `dup=0`.

Source files
------------

// File: rtl/pdecoder_acc_if.sv
// Handshake bundle for pdecoder_acc: an index stream in, a frame result out.
interface pdecoder_acc_if #(
  parameter int N = 3
);
  localparam int W = 2**N;

  logic           in_valid;
  logic           in_ready;
  logic [N-1:0]   idx;
  logic           last;
  logic           out_valid;
  logic           out_ready;
  logic [W-1:0]   out;
  logic [N:0]     count;
  logic           dup;

  // Decoder side: consumes indices, produces the frame result.
  modport slave (
    input  in_valid, idx, last, out_ready,
    output in_ready, out_valid, out, count, dup
  );

  // Environment side: produces indices, consumes the frame result.
  modport master (
    output in_valid, idx, last, out_ready,
    input  in_ready, out_valid, out, count, dup
  );
endinterface

// File: rtl/pdecoder_acc.sv
// pdecoder_acc: decodes a stream of encoder indices into an accumulated
// one-hot request vector and presents it, with a saturating beat count and
// a duplicate flag, once the frame's last beat has been accepted.
module pdecoder_acc #(
  parameter int N = 3
) (
  input  logic           clk_i,
  input  logic           rst_i,
  pdecoder_acc_if.slave  bus
);
  localparam int W = 2**N;

  localparam logic [0:0] ST_ACC = 1'b0;
  localparam logic [0:0] ST_OUT = 1'b1;

  localparam logic [N:0] CNT_MAX = {(N+1){1'b1}};

  // One-hot decode of an index into the vector width.
  function automatic logic [W-1:0] onehot(input logic [N-1:0] i);
    logic [W-1:0] one;
    one    = {{(W-1){1'b0}}, 1'b1};
    onehot = one << i;
  endfunction

  // Beat counter increment that sticks at all-ones instead of wrapping.
  function automatic logic [N:0] sat_inc(input logic [N:0] c);
    if (c == CNT_MAX) begin
      sat_inc = c;
    end else begin
      sat_inc = c + {{N{1'b0}}, 1'b1};
    end
  endfunction

  logic [0:0]   state_q, state_d;
  logic [W-1:0] vec_q,   vec_d;
  logic [N:0]   cnt_q,   cnt_d;
  logic         dupr_q,  dupr_d;
  logic [W-1:0] out_q,   out_d;
  logic [N:0]   count_q, count_d;
  logic         dup_q,   dup_d;

  // Next-state: accumulate accepted beats in ACC, hold the result in OUT
  // until the downstream handshake, then clear everything for the next frame.
  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    cnt_d   = cnt_q;
    dupr_d  = dupr_q;
    out_d   = out_q;
    count_d = count_q;
    dup_d   = dup_q;
    case (state_q)
      ST_ACC: begin
        if (bus.in_valid) begin
          vec_d  = vec_q | onehot(bus.idx);
          cnt_d  = sat_inc(cnt_q);
          dupr_d = dupr_q | vec_q[bus.idx];
          if (bus.last) begin
            // Result registers capture the values including this last beat.
            state_d = ST_OUT;
            out_d   = vec_d;
            count_d = cnt_d;
            dup_d   = dupr_d;
          end else begin
            state_d = ST_ACC;
          end
        end else begin
          state_d = ST_ACC;
        end
      end
      ST_OUT: begin
        if (bus.out_ready) begin
          state_d = ST_ACC;
          vec_d   = {W{1'b0}};
          cnt_d   = {(N+1){1'b0}};
          dupr_d  = 1'b0;
          out_d   = {W{1'b0}};
          count_d = {(N+1){1'b0}};
          dup_d   = 1'b0;
        end else begin
          state_d = ST_OUT;
        end
      end
      default: begin
        state_d = ST_ACC;
        vec_d   = {W{1'b0}};
        cnt_d   = {(N+1){1'b0}};
        dupr_d  = 1'b0;
        out_d   = {W{1'b0}};
        count_d = {(N+1){1'b0}};
        dup_d   = 1'b0;
      end
    endcase
  end

  // State and result registers; reset discards any partial or pending frame.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_ACC;
      vec_q   <= {W{1'b0}};
      cnt_q   <= {(N+1){1'b0}};
      dupr_q  <= 1'b0;
      out_q   <= {W{1'b0}};
      count_q <= {(N+1){1'b0}};
      dup_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      cnt_q   <= cnt_d;
      dupr_q  <= dupr_d;
      out_q   <= out_d;
      count_q <= count_d;
      dup_q   <= dup_d;
    end
  end

  // Handshake strobes are pure decodes of the registered state, so neither
  // depends combinationally on in_valid or out_ready.
  assign bus.in_ready  = (state_q == ST_ACC);
  assign bus.out_valid = (state_q == ST_OUT);
  assign bus.out       = out_q;
  assign bus.count     = count_q;
  assign bus.dup       = dup_q;
endmodule

// File: tb/tb_pdecoder_acc.sv
// Self-checking bench for pdecoder_acc: directed frame table, hand-written
// reset sequences, and random frames checked against a frame-level model.
module tb_pdecoder_acc;
  logic clk = 1'b0;
  logic rst = 1'b1;

  pdecoder_acc_if #(.N(3)) bus ();

  pdecoder_acc #(.N(3)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cur_ids[$];

  typedef struct {
    int               len;
    logic [3:0][2:0]  ids;    // beat i uses ids[min(i,3)]
    int               stall;
    bit               hold;
    logic [7:0]       e_out;
    logic [3:0]       e_cnt;
    logic             e_dup;
  } vec_t;

  vec_t tbl[6];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // Drive the frame held in cur_ids, then check the presented result and
  // the return to ACC; optional output backpressure and input gaps.
  task automatic run_frame(input int stall, input bit hold, input bit gaps,
                           input logic [7:0] e_out, input logic [3:0] e_cnt,
                           input logic e_dup, input string nm);
    int n;
    n = cur_ids.size();
    for (int i = 0; i < n; i++) begin
      if (gaps && ($urandom_range(0, 3) == 0)) begin
        bus.in_valid  = 1'b0;
        bus.idx       = 3'($urandom);
        bus.last      = 1'($urandom);
        bus.out_ready = 1'($urandom);
        step();
      end
      chk({nm, "_in_ready"}, {31'd0, bus.in_ready}, 32'd1);
      chk({nm, "_acc_quiet"}, {18'd0, bus.out_valid, bus.out, bus.count, bus.dup}, 32'd0);
      bus.in_valid  = 1'b1;
      bus.idx       = 3'(cur_ids[i]);
      bus.last      = (i == n - 1);
      bus.out_ready = (i == n - 1) ? (stall == 0) : 1'($urandom);
      step();
    end
    bus.in_valid = hold;
    bus.idx      = 3'd7;
    bus.last     = hold;
    for (int s = 0; s <= stall; s++) begin
      if (s > 0) step();
      chk({nm, "_out_valid"}, {31'd0, bus.out_valid}, 32'd1);
      chk({nm, "_in_ready_low"}, {31'd0, bus.in_ready}, 32'd0);
      chk({nm, "_out"}, {24'd0, bus.out}, {24'd0, e_out});
      chk({nm, "_count"}, {28'd0, bus.count}, {28'd0, e_cnt});
      chk({nm, "_dup"}, {31'd0, bus.dup}, {31'd0, e_dup});
    end
    bus.out_ready = 1'b1;
    step();
    bus.in_valid  = 1'b0;
    bus.last      = 1'b0;
    bus.out_ready = 1'b0;
    chk({nm, "_post_valid"}, {31'd0, bus.out_valid}, 32'd0);
    chk({nm, "_post_ready"}, {31'd0, bus.in_ready}, 32'd1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] m_out;
    logic       m_dup;
    int         len;
    int         v;

    // Directed frames: {len, ids (ids[0] first), stall, hold, out, count, dup}
    tbl[0] = '{3,  {3'd1, 3'd1, 3'd4, 3'd5}, 0, 1'b0, 8'b0011_0010, 4'd3,  1'b0};
    tbl[1] = '{2,  {3'd1, 3'd1, 3'd1, 3'd1}, 0, 1'b0, 8'b0000_0010, 4'd2,  1'b1};
    tbl[2] = '{1,  {3'd0, 3'd0, 3'd0, 3'd0}, 0, 1'b0, 8'b0000_0001, 4'd1,  1'b0};
    tbl[3] = '{2,  {3'd0, 3'd0, 3'd0, 3'd2}, 5, 1'b1, 8'b0000_0101, 4'd2,  1'b0};
    tbl[4] = '{1,  {3'd3, 3'd3, 3'd3, 3'd3}, 0, 1'b0, 8'b0000_1000, 4'd1,  1'b0};
    tbl[5] = '{17, {3'd7, 3'd7, 3'd7, 3'd7}, 0, 1'b0, 8'b1000_0000, 4'd15, 1'b1};

    bus.in_valid  = 1'b0;
    bus.idx       = 3'd0;
    bus.last      = 1'b0;
    bus.out_ready = 1'b0;
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    step();
    chk("reset_in_ready", {31'd0, bus.in_ready}, 32'd1);
    chk("reset_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("reset_outputs", {20'd0, bus.out, bus.count, bus.dup}, 32'd0);

    for (int t = 0; t < 6; t++) begin
      cur_ids.delete();
      for (int i = 0; i < tbl[t].len; i++) cur_ids.push_back(int'(tbl[t].ids[(i < 3) ? i : 3]));
      run_frame(tbl[t].stall, tbl[t].hold, 1'b0, tbl[t].e_out, tbl[t].e_cnt,
                tbl[t].e_dup, $sformatf("tbl%0d", t));
    end

    // Abort mid-frame; reset also wins over a last beat offered in its cycle.
    bus.in_valid = 1'b1; bus.idx = 3'd3; bus.last = 1'b0;
    step();
    bus.idx = 3'd6;
    step();
    bus.idx = 3'd5; bus.last = 1'b1; rst = 1'b1;
    step();
    rst = 1'b0; bus.in_valid = 1'b0; bus.last = 1'b0;
    chk("abort_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("abort_outputs", {20'd0, bus.out, bus.count, bus.dup}, 32'd0);
    step();
    chk("abort_still_quiet", {31'd0, bus.out_valid}, 32'd0);
    cur_ids.delete();
    cur_ids.push_back(0);
    run_frame(0, 1'b0, 1'b0, 8'b0000_0001, 4'd1, 1'b0, "after_abort");

    // Reset while a result is pending discards it.
    bus.in_valid = 1'b1; bus.idx = 3'd4; bus.last = 1'b1; bus.out_ready = 1'b0;
    step();
    bus.in_valid = 1'b0; bus.last = 1'b0;
    chk("pending_valid", {31'd0, bus.out_valid}, 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("pending_dropped", {18'd0, bus.out_valid, bus.out, bus.count, bus.dup}, 32'd0);
    cur_ids.delete();
    cur_ids.push_back(6);
    run_frame(0, 1'b0, 1'b0, 8'b0100_0000, 4'd1, 1'b0, "after_pending");

    // Random frames against a frame-level model: set union, sticky repeat
    // detection, and a beat count clipped at 15.
    for (int f = 0; f < 40; f++) begin
      len = $urandom_range(1, 20);
      cur_ids.delete();
      m_out = 8'd0;
      m_dup = 1'b0;
      for (int i = 0; i < len; i++) begin
        v = $urandom_range(0, 7);
        cur_ids.push_back(v);
        if (m_out[v]) m_dup = 1'b1;
        m_out[v] = 1'b1;
      end
      run_frame($urandom_range(0, 3), 1'($urandom), 1'b1, m_out,
                4'((len > 15) ? 15 : len), m_dup, $sformatf("rnd%0d", f));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
